// File: rtl/gray_code_counter.sv
// Registered Gray-code counter with matching binary count and rollover pulse.
// gray and binary are both loaded from the same next-state value.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Priority: clear, then load, then enabled up/down step, else hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_bin;
    end else if (en) begin
      if (up) begin
        cnt_d  = cnt_q + ONE;
        wrap_d = &cnt_q;
      end else begin
        cnt_d  = cnt_q - ONE;
        wrap_d = ~|cnt_q;
      end
    end
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign binary = cnt_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: directed vector table, reset
// corner cases, and a randomized run against a behavioural count model.
module tb_gray_code_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_bin;
  logic         en;
  logic         up;
  logic [W-1:0] gray;
  logic [W-1:0] binary;
  logic         wrap;

  int errors = 0;
  int checks = 0;

  int unsigned model_cnt  = 0;
  bit          model_wrap = 0;

  typedef struct {
    logic         c;
    logic         l;
    logic [W-1:0] lb;
    logic         e;
    logic         u;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  gray_code_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load),
    .load_bin (load_bin),
    .en       (en),
    .up       (up),
    .gray     (gray),
    .binary   (binary),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference for the downstream gray_to_binary stage: prefix XOR from the MSB.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic void addVec(input logic c, input logic l, input logic [W-1:0] lb,
                                 input logic e, input logic u, input logic [W-1:0] eb,
                                 input logic [W-1:0] eg, input logic ew);
    vec_t v;
    v.c = c; v.l = l; v.lb = lb; v.e = e; v.u = u;
    v.exp_bin = eb; v.exp_gray = eg; v.exp_wrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs (called just after a rising edge), advance the model, take one edge.
  task automatic applyStimulus(input logic c, input logic l, input logic [W-1:0] lb,
                               input logic e, input logic u);
    clear = c; load = l; load_bin = lb; en = e; up = u;
    model_wrap = 0;
    if (c) model_cnt = 0;
    else if (l) model_cnt = lb;
    else if (e && u) begin
      model_wrap = (model_cnt == MOD - 1);
      model_cnt  = (model_cnt + 1) % MOD;
    end else if (e) begin
      model_wrap = (model_cnt == 0);
      model_cnt  = (model_cnt + MOD - 1) % MOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_bin"},  binary, model_cnt);
    checkOutput({tag, "_wrap"}, wrap, model_wrap);
    checkOutput({tag, "_conv_gray"}, g2b(gray), model_cnt);
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    logic c, l, e, u;
    logic [W-1:0] lb;

    // Up-count 0 -> 15, then wrap to 0.
    addVec(0,0,4'd0,1,1, 4'd1,  4'b0001, 0);
    addVec(0,0,4'd0,1,1, 4'd2,  4'b0011, 0);
    addVec(0,0,4'd0,1,1, 4'd3,  4'b0010, 0);
    addVec(0,0,4'd0,1,1, 4'd4,  4'b0110, 0);
    addVec(0,0,4'd0,1,1, 4'd5,  4'b0111, 0);
    addVec(0,0,4'd0,1,1, 4'd6,  4'b0101, 0);
    addVec(0,0,4'd0,1,1, 4'd7,  4'b0100, 0);
    addVec(0,0,4'd0,1,1, 4'd8,  4'b1100, 0);
    addVec(0,0,4'd0,1,1, 4'd9,  4'b1101, 0);
    addVec(0,0,4'd0,1,1, 4'd10, 4'b1111, 0);
    addVec(0,0,4'd0,1,1, 4'd11, 4'b1110, 0);
    addVec(0,0,4'd0,1,1, 4'd12, 4'b1010, 0);
    addVec(0,0,4'd0,1,1, 4'd13, 4'b1011, 0);
    addVec(0,0,4'd0,1,1, 4'd14, 4'b1001, 0);
    addVec(0,0,4'd0,1,1, 4'd15, 4'b1000, 0);
    addVec(0,0,4'd0,1,1, 4'd0,  4'b0000, 1);
    addVec(0,0,4'd0,0,1, 4'd0,  4'b0000, 0);
    // Down-count across zero.
    addVec(0,0,4'd0,1,0, 4'd15, 4'b1000, 1);
    addVec(0,0,4'd0,1,0, 4'd14, 4'b1001, 0);
    // Load with en high, then count up.
    addVec(0,1,4'd10,1,1, 4'd10, 4'b1111, 0);
    addVec(0,0,4'd0,1,1,  4'd11, 4'b1110, 0);
    // clear + load + en at 7: clear wins.
    addVec(0,1,4'd7,0,0,  4'd7,  4'b0100, 0);
    addVec(1,1,4'd3,1,1,  4'd0,  4'b0000, 0);
    // Hold at 9 for five cycles.
    addVec(0,1,4'd9,0,0,  4'd9,  4'b1101, 0);
    for (int i = 0; i < 5; i++) addVec(0,0,4'd0,0,1, 4'd9, 4'b1101, 0);
    // load + en at the wrap boundary: load wins, no wrap.
    addVec(0,1,4'd15,0,0, 4'd15, 4'b1000, 0);
    addVec(0,1,4'd4,1,1,  4'd4,  4'b0110, 0);
    addVec(1,0,4'd0,0,0,  4'd0,  4'b0000, 0);

    rst_n = 1'b0; clear = 0; load = 0; load_bin = '0; en = 0; up = 1;
    #12;
    checkOutput("reset_gray", gray, 0);
    checkOutput("reset_bin",  binary, 0);
    checkOutput("reset_wrap", wrap, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0; model_wrap = 0;

    foreach (vecs[k]) begin
      prev_gray = gray;
      applyStimulus(vecs[k].c, vecs[k].l, vecs[k].lb, vecs[k].e, vecs[k].u);
      checkOutput($sformatf("vec%0d_bin", k),  binary, vecs[k].exp_bin);
      checkOutput($sformatf("vec%0d_gray", k), gray,   vecs[k].exp_gray);
      checkOutput($sformatf("vec%0d_wrap", k), wrap,   vecs[k].exp_wrap);
      if (!vecs[k].c && !vecs[k].l && vecs[k].e)
        checkOutput($sformatf("vec%0d_onebit", k), $countones(gray ^ prev_gray), 1);
    end

    // Asynchronous reset mid-count at 5, between edges.
    for (int i = 0; i < 5; i++) applyStimulus(0,0,'0,1,1);
    checkOutput("pre_reset_bin", binary, 5);
    en = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_gray", gray, 0);
    checkOutput("midreset_bin",  binary, 0);
    checkOutput("midreset_wrap", wrap, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0; model_wrap = 0;

    // Reset kills a pending wrap pulse.
    applyStimulus(0,1,4'd15,0,0);
    applyStimulus(0,0,'0,1,1);
    checkOutput("wrap_before_reset", wrap, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("wrap_killed", wrap, 0);
    checkOutput("wrap_killed_gray", gray, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0; model_wrap = 0;
    applyStimulus(0,0,'0,1,0);
    checkModel("post_reset");

    // Randomized en/up/load/clear mix against the model and the converter.
    for (int n = 0; n < 1000; n++) begin
      c  = ($urandom_range(99) < 3);
      l  = ($urandom_range(99) < 10);
      e  = ($urandom_range(99) < 75);
      u  = $urandom_range(1);
      lb = W'($urandom_range(MOD - 1));
      prev_gray = gray;
      applyStimulus(c, l, lb, e, u);
      checkModel($sformatf("rnd%0d", n));
      checkOutput($sformatf("rnd%0d_conv_vs_bin", n), g2b(gray), binary);
      if (!c && !l && e)
        checkOutput($sformatf("rnd%0d_onebit", n), $countones(gray ^ prev_gray), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
